burst_reader: RTL and testbench

// - Streams a linear memory region out as octets, fetching it in 4x64-bit read bursts over burst_bus_if.
// - Read-side counterpart of the octet burst writer: same start address, burst size, address step and byte order.
// - Two-slot ping-pong buffer: one burst is prefetched while the other drains, so the consumer sees no gaps at steady state.

---
 rtl/burst_reader_if.sv | 26 ++
 rtl/burst_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_burst_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_reader_if.sv
// burst_bus_if: burst memory bus shared by the octet burst reader and writer.
// One clock travels with the bus. The master drives cmd/cmd_en/addr/wr_data/
// data_mask; the memory side answers with ready (command accepted) and a stream
// of rd_data words qualified by rd_data_valid.
interface burst_bus_if (
  input logic clk
);
  logic [2:0]  cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic        ready;
  logic [63:0] rd_data;
  logic        rd_data_valid;

  modport master (
    input  clk, ready, rd_data, rd_data_valid,
    output cmd, cmd_en, addr, wr_data, data_mask
  );

  modport slave (
    input  clk, cmd, cmd_en, addr, wr_data, data_mask,
    output ready, rd_data, rd_data_valid
  );
endinterface

// File: rtl/burst_reader.sv
// burst_reader: streams a linear memory region out as octets.
// Memory is fetched in 4x64-bit read bursts into a two-slot ping-pong buffer,
// so one burst is prefetched while the other drains to the consumer.
// Ports:
//   mem        burst_bus_if.master, carries the single clock (mem.clk)
//   reset      asynchronous active-low reset
//   enable     1 = new bursts may be requested
//   restart    one-cycle pulse: flush both slots, reload START_ADDR
//   out_data   current octet (registered)
//   out_valid  out_data is valid (registered)
//   out_ready  consumer accepts out_data when out_valid && out_ready
// Optional feature: define BURST_READER_WRAP_EN to reload START_ADDR after the
// burst at WRAP_ADDR completes; otherwise the address free-runs (21-bit wrap).
module burst_reader #(
  parameter logic [20:0] START_ADDR = 21'h000500,
  parameter logic [20:0] ADDR_STEP  = 21'd16,
  parameter logic [20:0] WRAP_ADDR  = 21'h001FF0
) (
  burst_bus_if.master mem,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2
  } state_t;

  state_t                 state_r, state_next_s;
  logic                   cmd_en_r, cmd_en_next_s;
  logic [1:0][3:0][63:0]  slot_r, slot_next_s;
  logic [1:0]             full_r, full_next_s;
  logic                   fill_sel_r, fill_sel_next_s;
  logic [1:0]             word_cnt_r, word_cnt_next_s;
  logic                   drain_sel_r, drain_sel_next_s;
  logic [4:0]             drain_idx_r, drain_idx_next_s;  // {word[1:0], byte[2:0]}
  logic                   discard_r, discard_next_s;
  logic [20:0]            addr_r, addr_next_s;
  logic [7:0]             out_data_r, out_data_next_s;
  logic                   out_valid_r, out_valid_next_s;
  logic [63:0]            cur_word_s;
  logic                   burst_done_s;
  logic                   drop_s;

  // Byte 0 of a word is its most significant octet.
  function automatic logic [7:0] pick_byte(input logic [63:0] word, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = word >> {3'd7 - idx, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic [20:0] advance_addr(input logic [20:0] a);
`ifdef BURST_READER_WRAP_EN
    if (a == WRAP_ADDR) begin
      return START_ADDR;
    end else begin
      return a + ADDR_STEP;
    end
`else
    return a + ADDR_STEP;
`endif
  endfunction

`ifndef BURST_READER_WRAP_EN
  logic unused_wrap_s;
  assign unused_wrap_s = ^WRAP_ADDR;
`endif

  assign mem.cmd       = 3'd0;
  assign mem.data_mask = 8'd0;
  assign mem.wr_data   = 64'd0;
  assign mem.cmd_en    = cmd_en_r;
  assign mem.addr      = addr_r;
  assign out_data      = out_data_r;
  assign out_valid     = out_valid_r;

  assign burst_done_s = (state_r == ST_RECV) && mem.rd_data_valid && (word_cnt_r == 2'd3);
  // A burst is thrown away if a restart arrived while it was in flight, or arrives now.
  assign drop_s       = discard_r || restart;

  // FSM state register and registered command strobe
  always_ff @(posedge mem.clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cmd_en_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cmd_en_r <= cmd_en_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && !full_r[fill_sel_r] && !restart) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A request is never withdrawn once issued.
        if (mem.ready) begin
          state_next_s = ST_RECV;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RECV: begin
        if (burst_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output logic: command strobe is high for the whole REQ state
  always_comb begin
    cmd_en_next_s = 1'b0;
    if (state_next_s == ST_REQ) begin
      cmd_en_next_s = 1'b1;
    end else begin
      cmd_en_next_s = 1'b0;
    end
  end

  // Buffer fill, drain and restart bookkeeping
  always_comb begin
    slot_next_s      = slot_r;
    full_next_s      = full_r;
    fill_sel_next_s  = fill_sel_r;
    word_cnt_next_s  = word_cnt_r;
    drain_sel_next_s = drain_sel_r;
    drain_idx_next_s = drain_idx_r;
    discard_next_s   = discard_r;
    addr_next_s      = addr_r;

    if ((state_r == ST_RECV) && mem.rd_data_valid) begin
      word_cnt_next_s = word_cnt_r + 2'd1;
      if (!drop_s) begin
        slot_next_s[fill_sel_r][word_cnt_r] = mem.rd_data;
      end else begin
        slot_next_s = slot_r;
      end
      if (word_cnt_r == 2'd3) begin
        discard_next_s = 1'b0;
        if (drop_s) begin
          addr_next_s = START_ADDR;
        end else begin
          full_next_s[fill_sel_r] = 1'b1;
          fill_sel_next_s         = ~fill_sel_r;
          addr_next_s             = advance_addr(addr_r);
        end
      end else begin
        discard_next_s = discard_r;
      end
    end else begin
      word_cnt_next_s = word_cnt_r;
    end

    // fill_sel differs from drain_sel whenever both are active, so the
    // full flags touched here and above never coincide.
    if (out_valid_r && out_ready) begin
      drain_idx_next_s = drain_idx_r + 5'd1;
      if (drain_idx_r == 5'd31) begin
        full_next_s[drain_sel_r] = 1'b0;
        drain_sel_next_s         = ~drain_sel_r;
      end else begin
        drain_sel_next_s = drain_sel_r;
      end
    end else begin
      drain_idx_next_s = drain_idx_r;
    end

    if (restart) begin
      full_next_s      = 2'b00;
      fill_sel_next_s  = 1'b0;
      drain_sel_next_s = 1'b0;
      drain_idx_next_s = 5'd0;
      if (state_r == ST_IDLE) begin
        addr_next_s    = START_ADDR;
        discard_next_s = 1'b0;
      end else if (!burst_done_s) begin
        // In-flight burst runs to completion; its address reload happens then.
        discard_next_s = 1'b1;
      end else begin
        discard_next_s = 1'b0;
      end
    end else begin
      full_next_s = full_next_s;
    end
  end

  // Registered octet output, derived from the post-update buffer state
  always_comb begin
    out_valid_next_s = full_next_s[drain_sel_next_s];
    cur_word_s       = slot_next_s[drain_sel_next_s][drain_idx_next_s[4:3]];
    if (out_valid_next_s) begin
      out_data_next_s = pick_byte(cur_word_s, drain_idx_next_s[2:0]);
    end else begin
      out_data_next_s = out_data_r;
    end
  end

  // Datapath registers
  always_ff @(posedge mem.clk or negedge reset) begin
    if (!reset) begin
      slot_r      <= '0;
      full_r      <= 2'b00;
      fill_sel_r  <= 1'b0;
      word_cnt_r  <= 2'd0;
      drain_sel_r <= 1'b0;
      drain_idx_r <= 5'd0;
      discard_r   <= 1'b0;
      addr_r      <= START_ADDR;
      out_data_r  <= 8'd0;
      out_valid_r <= 1'b0;
    end else begin
      slot_r      <= slot_next_s;
      full_r      <= full_next_s;
      fill_sel_r  <= fill_sel_next_s;
      word_cnt_r  <= word_cnt_next_s;
      drain_sel_r <= drain_sel_next_s;
      drain_idx_r <= drain_idx_next_s;
      discard_r   <= discard_next_s;
      addr_r      <= addr_next_s;
      out_data_r  <= out_data_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

endmodule

// File: tb/tb_burst_reader.sv
// tb_burst_reader: directed self-checking bench for burst_reader.
// A memory responder returns words whose octets are (address + offset)[7:0];
// a consumer checks every accepted octet against an address-sequence model.
module tb_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  burst_bus_if bus (.clk(clk));

  logic       reset;
  logic       enable;
  logic       restart;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  burst_reader #(.WRAP_ADDR(21'h000520)) dut (
    .mem       (bus),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] model_next(input logic [20:0] a);
`ifdef BURST_READER_WRAP_EN
    if (a == 21'h000520) return 21'h000500;
    else return a + 21'd16;
`else
    return a + 21'd16;
`endif
  endfunction

  function automatic logic [63:0] mem_word(input logic [20:0] a, input int w);
    logic [63:0] v;
    logic [20:0] t;
    v = 64'd0;
    for (int j = 0; j < 8; j++) begin
      t = a + 21'(8 * w + j);
      v = {v[55:0], t[7:0]};
    end
    return v;
  endfunction

  // Memory responder
  logic        ready_ctrl = 1'b0;
  logic        inject_stray = 1'b0;
  int          pend = 0;
  int          words_sent = 0;
  logic [20:0] resp_addr = 21'd0;
  logic [20:0] acc_log[$];

  initial begin
    bus.ready         = 1'b0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = 64'd0;
    forever begin
      @(negedge clk);
      bus.rd_data_valid = 1'b0;
      if (pend > 0) begin
        bus.rd_data       = mem_word(resp_addr, 4 - pend);
        bus.rd_data_valid = 1'b1;
        pend--;
        words_sent++;
      end else if (inject_stray) begin
        bus.rd_data       = 64'hDEAD_BEEF_CAFE_F00D;
        bus.rd_data_valid = 1'b1;
        inject_stray      = 1'b0;
      end
      bus.ready = ready_ctrl;
      if (bus.cmd_en && bus.ready && pend == 0 && reset) begin
        acc_log.push_back(bus.addr);
        resp_addr = bus.addr;
        pend      = 4;
      end
    end
  end

  // Consumer with octet model and hold-stability check
  int          cons_mode = 0;   // 0 never ready, 1 always, 2 random
  int          n_bytes = 0;
  logic [20:0] exp_addr = 21'h000500;
  int          exp_k = 0;
  logic        prev_hold = 1'b0;
  logic        prev_rs = 1'b0;
  logic [7:0]  prev_data = 8'd0;

  initial begin
    logic [20:0] t;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (prev_hold && !restart && !prev_rs) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(prev_data));
        end
        case (cons_mode)
          0:       out_ready = 1'b0;
          1:       out_ready = 1'b1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid && out_ready && !restart) begin
          t = exp_addr + 21'(exp_k);
          check("octet", 64'(out_data), 64'(t[7:0]));
          n_bytes++;
          exp_k++;
          if (exp_k == 32) begin
            exp_k    = 0;
            exp_addr = model_next(exp_addr);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_rs   = restart;
      end else begin
        out_ready = 1'b0;
        prev_hold = 1'b0;
        prev_rs   = 1'b0;
      end
    end
  end

  // Main directed sequence
  initial begin
    logic [20:0] a;
    int base;
    int ws;
    reset   = 1'b0;
    enable  = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_en", 64'(bus.cmd_en), 64'd0);
    check("rst_addr", 64'(bus.addr), 64'h500);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("const_cmd", 64'(bus.cmd), 64'd0);
    check("const_mask", 64'(bus.data_mask), 64'd0);
    check("const_wr_data", bus.wr_data, 64'd0);

    // First request appears one cycle after release and is held while ready=0
    reset = 1'b1;
    @(negedge clk);
    check("first_cmd_en", 64'(bus.cmd_en), 64'd1);
    check("first_addr", 64'(bus.addr), 64'h500);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_cmd_en", 64'(bus.cmd_en), 64'd1);
      check("held_addr", 64'(bus.addr), 64'h500);
    end
    check("no_accept_yet", 64'(acc_log.size()), 64'd0);

    // Consumer stalled: exactly two bursts fetched, then nothing
    ready_ctrl = 1'b1;
    repeat (60) @(negedge clk);
    check("two_bursts", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() >= 2) begin
      check("burst0_addr", 64'(acc_log[0]), 64'h500);
      check("burst1_addr", 64'(acc_log[1]), 64'h510);
    end
    check("stall_cmd_en", 64'(bus.cmd_en), 64'd0);
    check("stall_addr", 64'(bus.addr), 64'h520);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data", 64'(out_data), 64'h00);

    // A stray rd_data_valid while idle must be ignored
    inject_stray = 1'b1;
    repeat (6) @(negedge clk);
    check("stray_data", 64'(out_data), 64'h00);
    check("stray_valid", 64'(out_valid), 64'd1);
    check("stray_no_req", 64'(acc_log.size()), 64'd2);

    // Random back-pressure over 64 bursts
    cons_mode = 2;
    for (int c = 0; c < 20000 && n_bytes < 2048; c++) @(negedge clk);
    check("random_drain_done", 64'(n_bytes >= 2048), 64'd1);
    cons_mode = 0;
    check("random_log_size", 64'(acc_log.size() >= 64), 64'd1);
    a = 21'h000500;
    for (int i = 0; i < 64 && i < acc_log.size(); i++) begin
      check("addr_seq", 64'(acc_log[i]), 64'(a));
      a = model_next(a);
    end

    // Drain everything, then restart while a burst is in RECV after word 1
    enable    = 1'b0;
    cons_mode = 1;
    repeat (150) @(negedge clk);
    check("drained_valid", 64'(out_valid), 64'd0);
    cons_mode = 0;
    base = acc_log.size();
    ws   = words_sent;
    enable = 1'b1;
    for (int c = 0; c < 100 && words_sent < ws + 2; c++) @(posedge clk);
    check("recv_started", 64'(words_sent >= ws + 2), 64'd1);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    exp_addr = 21'h000500;
    exp_k    = 0;
    check("restart_valid", 64'(out_valid), 64'd0);
    for (int c = 0; c < 100 && acc_log.size() <= base + 1; c++) @(negedge clk);
    check("restart_req", 64'(acc_log.size() > base + 1), 64'd1);
    check("discarded_valid", 64'(out_valid), 64'd0);
    if (acc_log.size() > base + 1) begin
      check("restart_addr", 64'(acc_log[base + 1]), 64'h500);
    end

    // Refill and run through the wrap point
    cons_mode = 1;
    for (int c = 0; c < 1000 && acc_log.size() <= base + 4; c++) @(negedge clk);
    check("wrap_reached", 64'(acc_log.size() > base + 4), 64'd1);
    a = 21'h000500;
    for (int i = base + 1; i <= base + 4 && i < acc_log.size(); i++) begin
      check("wrap_seq", 64'(acc_log[i]), 64'(a));
      a = model_next(a);
    end

    // Restart in IDLE with data pending
    enable    = 1'b0;
    cons_mode = 0;
    repeat (60) @(negedge clk);
    check("idle_valid", 64'(out_valid), 64'd1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("idle_restart_valid", 64'(out_valid), 64'd0);
    check("idle_restart_addr", 64'(bus.addr), 64'h500);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
